// File: rtl/ap3_gmux_pkg.sv
// Shared definitions for the GMUX_CLK quadrant sequencer: quadrant indices,
// sequencer states and the power-down reset pattern.
package ap3_gmux_pkg;

  localparam logic [1:0] Q_TL = 2'd0;
  localparam logic [1:0] Q_TR = 2'd1;
  localparam logic [1:0] Q_BL = 2'd2;
  localparam logic [1:0] Q_BR = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAKE   = 2'd1,
    ARM    = 2'd2,
    SETTLE = 2'd3
  } seq_state_t;

  localparam logic [3:0] VLP_RST = 4'hF;

endpackage

// File: rtl/gmux_rr_arb4.sv
// Round-robin pick of the first set mismatch bit at or after ptr (cyclic).
// Latency: combinational. Backpressure: none; the caller samples gnt only when it can grant.
// Grant is only meaningful while gnt_vld is high.
module gmux_rr_arb4 (
  input  logic [3:0] mismatch,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       gnt_vld
);
  import ap3_gmux_pkg::*;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt     = ptr;
    gnt_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (mismatch[ptr + 2'(k)]) begin
        gnt     = ptr + 2'(k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmux_quad_seq.sv
// Orders per-quadrant SEN/DEN/DYNEN/VLP power-up/down sequences and SSEL changes for one GMUX_CLK.
// Latency: enable WAKE_CYCLES+1 edges to QON, disable SETTLE_CYCLES edges to VLP.
// Backpressure: one quadrant at a time; requests wait in IDLE, SSEL waits until SEN==0.
module gmux_quad_seq #(
  parameter int WAKE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] REQ_ON,
  input  logic [3:0] DYN_MODE,
  input  logic       SSEL_REQ,
  output logic [3:0] SEN,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] VLP,
  output logic       SSEL,
  output logic [3:0] QON,
  output logic       BUSY,
  output logic       SSEL_PEND
);
  import ap3_gmux_pkg::*;

  seq_state_t       state;
  logic [1:0]       q;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mismatch;
  logic [1:0]       gnt;
  logic             gnt_vld;

  assign mismatch = REQ_ON ^ QON;

  gmux_rr_arb4 u_arb (
    .mismatch (mismatch),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      q         <= Q_TL;
      rr_ptr    <= Q_TL;
      cnt       <= '0;
      SEN       <= 4'h0;
      DEN       <= 4'h0;
      DYNEN     <= 4'h0;
      VLP       <= VLP_RST;
      SSEL      <= 1'b0;
      QON       <= 4'h0;
      BUSY      <= 1'b0;
      SSEL_PEND <= 1'b0;
    end else begin
      SSEL_PEND <= (SSEL_REQ != SSEL) && ((SEN != 4'h0) || (state != IDLE));
      case (state)
        IDLE: begin
          // Source switching pre-empts any grant while every quadrant is static-disabled.
          if ((SSEL_REQ != SSEL) && (SEN == 4'h0)) begin
            SSEL <= SSEL_REQ;
          end else if (gnt_vld) begin
            q      <= gnt;
            rr_ptr <= gnt + 2'd1;
            BUSY   <= 1'b1;
            if (REQ_ON[gnt]) begin
              VLP[gnt] <= 1'b0;
              cnt      <= CNT_W'(WAKE_CYCLES - 1);
              state    <= WAKE;
            end else begin
              DEN[gnt] <= 1'b0;
              QON[gnt] <= 1'b0;
              cnt      <= CNT_W'(SETTLE_CYCLES - 1);
              state    <= SETTLE;
            end
          end
        end
        WAKE: begin
          if (cnt == '0) begin
            SEN[q]   <= 1'b1;
            DYNEN[q] <= DYN_MODE[q];
            state    <= ARM;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ARM: begin
          DEN[q] <= 1'b1;
          QON[q] <= 1'b1;
          state  <= IDLE;
          BUSY   <= 1'b0;
        end
        SETTLE: begin
          if (cnt == '0) begin
            SEN[q]   <= 1'b0;
            DYNEN[q] <= 1'b0;
            VLP[q]   <= 1'b1;
            state    <= IDLE;
            BUSY     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmux_quad_seq.sv
// Bench for gmux_quad_seq: timeline model checked every cycle, plus directed literal checks.
module tb_gmux_quad_seq;
  import ap3_gmux_pkg::*;

  localparam int W = 4;
  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [3:0] REQ_ON = 4'h0;
  logic [3:0] DYN_MODE = 4'h0;
  logic       SSEL_REQ = 1'b0;
  logic [3:0] SEN, DEN, DYNEN, VLP, QON;
  logic       SSEL, BUSY, SSEL_PEND;

  int checks = 0;
  int errors = 0;

  gmux_quad_seq #(.WAKE_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ_ON(REQ_ON), .DYN_MODE(DYN_MODE), .SSEL_REQ(SSEL_REQ),
    .SEN(SEN), .DEN(DEN), .DYNEN(DYNEN), .VLP(VLP), .SSEL(SSEL), .QON(QON),
    .BUSY(BUSY), .SSEL_PEND(SSEL_PEND)
  );

  always #5 CLK = ~CLK;

  // Model: one job at a time, described by its grant edge and how many edges have passed since.
  logic [3:0] m_sen, m_den, m_dyn, m_vlp, m_qon;
  logic       m_ssel, m_busy, m_pend;
  int         m_ptr, job_q, job_age;
  bit         job_act, job_en;

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_sen = 0; m_den = 0; m_dyn = 0; m_vlp = 4'hF; m_qon = 0;
      m_ssel = 0; m_busy = 0; m_pend = 0; m_ptr = 0; job_act = 0;
    end else begin
      logic [3:0] mm;
      bit pend_n, found;
      pend_n = (SSEL_REQ != m_ssel) && ((m_sen != 0) || job_act);
      if (job_act) begin
        job_age++;
        if (job_en) begin
          if (job_age == W) begin m_sen[job_q] = 1; m_dyn[job_q] = DYN_MODE[job_q]; end
          if (job_age == W + 1) begin m_den[job_q] = 1; m_qon[job_q] = 1; job_act = 0; end
        end else if (job_age == S) begin
          m_sen[job_q] = 0; m_dyn[job_q] = 0; m_vlp[job_q] = 1; job_act = 0;
        end
      end else if ((SSEL_REQ != m_ssel) && (m_sen == 0)) begin
        m_ssel = SSEL_REQ;
      end else begin
        mm = REQ_ON ^ m_qon;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && mm[(m_ptr + k) % 4]) begin
            found = 1;
            job_q = (m_ptr + k) % 4;
          end
        end
        if (found) begin
          job_act = 1; job_age = 0; job_en = REQ_ON[job_q];
          m_ptr = (job_q + 1) % 4;
          if (job_en) m_vlp[job_q] = 0;
          else begin m_den[job_q] = 0; m_qon[job_q] = 0; end
        end
      end
      m_busy = job_act;
      m_pend = pend_n;
    end
  end

  // Per-cycle compare plus structural invariants on the DUT.
  logic [3:0] prev_vlp;
  bit         prev_ok = 0;
  always @(negedge CLK) begin
    logic [22:0] got, exp;
    got = {SEN, DEN, DYNEN, VLP, SSEL, QON, BUSY, SSEL_PEND};
    exp = {m_sen, m_den, m_dyn, m_vlp, m_ssel, m_qon, m_busy, m_pend};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, exp);
    end
    checks++;
    if (((DEN & ~SEN) | (DEN & VLP)) !== 4'h0) begin
      errors++;
      $display("FAIL den_implies_on t=%0t DEN=%b SEN=%b VLP=%b", $time, DEN, SEN, VLP);
    end
    if (!RESETN) prev_ok = 0;
    else begin
      if (prev_ok) begin
        checks++;
        if ($countones(prev_vlp ^ VLP) > 1) begin
          errors++;
          $display("FAIL vlp_one_change t=%0t prev=%b now=%b", $time, prev_vlp, VLP);
        end
      end
      prev_vlp = VLP;
      prev_ok  = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    RESETN = 0; REQ_ON = 0; DYN_MODE = 0; SSEL_REQ = 0;
    step(2);
    RESETN = 1;
  endtask

  initial begin
    step(1);
    do_reset();
    chk("rst_vlp", {4'h0, VLP}, 8'h0F);
    chk("rst_misc", {SEN, DEN}, 8'h00);
    chk("rst_flags", {4'h0, SSEL, BUSY, SSEL_PEND, 1'b0}, 8'h00);

    // Single enable of TL
    REQ_ON = 4'b0001;
    step(1);
    chk("en_vlp_fall", {4'h0, VLP}, 8'h0E);
    chk("en_busy", {7'h0, BUSY}, 8'h01);
    step(3);
    chk("en_sen_t3", {4'h0, SEN}, 8'h00);
    step(1);
    chk("en_sen_t4", {SEN, DEN}, 8'h10);
    step(1);
    chk("en_den_t5", {DEN, QON}, 8'h11);
    chk("en_dyn_busy", {DYNEN, 3'h0, BUSY}, 8'h00);

    // All four quadrants in one go
    do_reset();
    REQ_ON = 4'hF;
    step(1);
    chk("all_first_tl", {4'h0, VLP}, 8'h0E);
    step(6);
    chk("all_second_tr", {QON, VLP}, 8'h1C);
    step(16);
    chk("all_t22", {4'h0, QON}, 8'h07);
    step(1);
    chk("all_t23", {QON, VLP}, 8'hF0);

    // Disable of TR
    do_reset();
    REQ_ON = 4'b0010;
    step(6);
    chk("dis_setup", {4'h0, QON}, 8'h02);
    REQ_ON = 4'b0000;
    step(1);
    chk("dis_den_fall", {DEN, QON}, 8'h00);
    chk("dis_sen_held", {SEN, VLP}, 8'h2D);
    step(2);
    chk("dis_done", {SEN, VLP}, 8'h0F);

    // SSEL blocked while on, applied before the next grant
    do_reset();
    REQ_ON = 4'b0001;
    step(6);
    SSEL_REQ = 1;
    step(1);
    chk("ssel_blocked", {6'h0, SSEL, SSEL_PEND}, 8'h01);
    REQ_ON = 4'b0000;
    step(2);
    REQ_ON = 4'b0001;
    step(1);
    chk("ssel_settled", {SEN, 2'h0, SSEL, SSEL_PEND}, 8'h01);
    step(1);
    chk("ssel_applied", {VLP, 2'h0, SSEL, SSEL_PEND}, 8'hF2);
    step(1);
    chk("ssel_then_grant", {4'h0, VLP}, 8'h0E);

    // Reset mid-WAKE of BL, restart from TL
    do_reset();
    REQ_ON = 4'b0111;
    step(14);
    chk("mid_wake_bl", {SEN, VLP}, 8'h38);
    RESETN = 0;
    #1;
    chk("async_rst", {SEN, VLP}, 8'h0F);
    chk("async_rst_q", {QON, 3'h0, BUSY}, 8'h00);
    @(negedge CLK); #1;
    RESETN = 1;
    step(1);
    chk("restart_tl", {4'h0, VLP}, 8'h0E);

    // Request dropped mid-WAKE of BR: enable completes, then disables
    do_reset();
    REQ_ON = 4'b1000; DYN_MODE = 4'b1000;
    step(2);
    REQ_ON = 4'b0000;
    step(4);
    chk("br_done", {QON, DYNEN}, 8'h88);
    chk("br_idle", {7'h0, BUSY}, 8'h00);
    step(1);
    chk("br_dis", {QON, 3'h0, BUSY}, 8'h01);
    chk("br_dis_sen", {SEN, DYNEN}, 8'h88);
    chk("br_idx", {6'h0, Q_BR}, 8'h03);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) REQ_ON = 4'($urandom);
      DYN_MODE = 4'($urandom);
      if ($urandom_range(0, 15) == 0) SSEL_REQ = ~SSEL_REQ;
      if ($urandom_range(0, 299) == 0) begin
        RESETN = 0;
        step(1);
        RESETN = 1;
      end
    end
    step(2);
    chk("pkg_idx", {2'h0, Q_TL, Q_TR, Q_BL}, 8'h06);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
